text_scanner: RTL
=================

# text_scanner

Raster text-mode display engine: the driver side of the character generator. It walks a VGA-style pixel raster and fetches a character code per 8×16 cell from a synchronous text RAM. It presents char/X/Y to the character generator, takes back the glyph bit and emits a registered pixel stream with aligned sync, data-enable and cursor overlay. It sits between the text buffer and the video output pins. `clk` is the pixel clock.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync pulse width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch
- `COLS`, 80, text columns (H_VISIBLE/8)
- `ROWS`, 30, text rows (V_VISIBLE/16)
- `ADDR_W`, 12, text RAM address width

Ports:
- `clk` in 1: pixel clock
- `rst_n` in 1: asynchronous, active-low reset
- `text_addr` out ADDR_W: text RAM read address
- `text_data` in 8: RAM read data, valid one cycle after the address; [3:0] char code, [7] inverse attribute, [6:4] ignored
- `char` out 4: to character generator
- `X` out 3: glyph column to character generator
- `Y` out 4: glyph row to character generator
- `value` in 1: glyph bit from character generator, combinational from char/X/Y
- `cursor_col` in 7: cursor column
- `cursor_row` in 5: cursor row
- `cursor_en` in 1: cursor enable
- `pixel` out 1: registered pixel
- `de` out 1: data enable, high in visible area
- `hsync` out 1: active-low
- `vsync` out 1: active-low
- `frame_start` out 1: one-cycle pulse with the first visible pixel of a frame

## Operation
- Stage 0 counters: `h` counts 0..H_TOTAL-1 (H_TOTAL=800) and wraps, incrementing `v` on wrap. `v` counts 0..V_TOTAL-1 (525) and wraps. Both are 10 bits.
- Visible area: h<H_VISIBLE and v<V_VISIBLE.
- Sync windows: hsync is active for H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC. vsync is active for V_VISIBLE+V_FRONT ≤ v < +V_SYNC. Both are derived from stage-0 counters.
- Stage 1 (registered):
  - `text_addr` = (v>>4)*COLS + (h>>3) when visible, else 0.
  - Also registers gx=h[2:0], gy=v[3:0], de, hs, vs, cursor-hit, first-pixel flag.
- Stage 2 (registered from stage 1):
  - `text_data` is valid during this stage.
  - `char`=text_data[3:0], `X`=stage-2 gx, `Y`=stage-2 gy; all combinational into the generator.
  - `value` returns in the same cycle.
- Stage 3 (registered outputs):
  - pixel = de & (value ^ text_data[7] ^ cursor_on).
  - cursor_on = cursor_en & cell hit & gy≥14 & blink.
  - A cell hit means cell column == cursor_col and cell row == cursor_row.
- Blink: a 5-bit frame counter increments at each frame wrap (v and h wrapping to 0); blink = counter[4].
- Cursor at an out-of-range position (col≥COLS or row≥ROWS) never hits.
- Multiplication is evaluated at ADDR_W width with no truncation for legal parameters. The largest address is ROWS*COLS-1 = 2399.

## Timing
- Outputs at cycle t+3 correspond to counter position at cycle t. Latency is fixed at 3 cycles with no stalls.
- Reset (async assert, sync release on next edge):
  - h=v=0, all pipeline regs clear, blink counter 0.
  - Outputs: pixel=0, de=0, hsync=1, vsync=1, frame_start=0, text_addr=0, char=0, X=0, Y=0.
- First edge after reset release: counters leave (0,0). First visible pixel appears on outputs 3 cycles later, with frame_start=1.
- Reset mid-frame: outputs take their reset values immediately (asynchronously). The frame restarts from (0,0) with no partial-line output.
- Line period is 800 cycles; frame period is 420 000 cycles.
- frame_start is high exactly once per frame.
- Simultaneous h and v wrap: v returns to 0 and the blink counter increments in the same edge.
- Sync signals stay aligned with de/pixel through the identical 3-stage delay.

## Test plan
- Reset: hold rst_n=0 → pixel=0, de=0, hsync=1, vsync=1, text_addr=0.
  - Assert rst_n mid-line → same values on the same cycle, with no clock edge needed.
- Line timing: count cycles after release → de high for 640 cycles starting at cycle 3, then hsync low for 96 cycles beginning 656 cycles after de rises; line period 800.
- Glyph path: RAM model with addr 0 = 0x01 (all-ones glyph), all other addresses 0x00 → pixels 0..7 of line 0 are 1, pixels 8..639 are 0.
  - Addr 0 = 0x80 (char 0, inverse) → pixels 0..7 of line 0 are 1.
- Addressing: at h=8, v=16, stage-1 text_addr=81; at h=639, v=479, text_addr=2399; outside the visible area text_addr=0.
- Frame: vsync low for 2 lines starting at line 490; frame_start pulses once per 420 000 cycles.
- Cursor: cursor_en=1, cursor at (2,1), blank text.
  - Frames 16–31 after reset → pixels x=16..23 on lines 30,31 are 1.
  - Frames 0–15 → those pixels are 0.
  - cursor_col=80 → no cursor pixels.

Source files
------------

// File: rtl/text_scanner_if.sv
// Signal bundle linking the text scanner to its text RAM, the character
// generator and the video output pins.
interface text_scanner_if #(
   parameter int ADDR_W = 12
);
   logic [ADDR_W-1:0] text_addr;
   logic [7:0]        text_data;
   logic [3:0]        char;
   logic [2:0]        X;
   logic [3:0]        Y;
   logic              value;
   logic [6:0]        cursor_col;
   logic [4:0]        cursor_row;
   logic              cursor_en;
   logic              pixel;
   logic              de;
   logic              hsync;
   logic              vsync;
   logic              frame_start;

   modport master (
      output text_addr, char, X, Y, pixel, de, hsync, vsync, frame_start,
      input  text_data, value, cursor_col, cursor_row, cursor_en
   );

   modport slave (
      input  text_addr, char, X, Y, pixel, de, hsync, vsync, frame_start,
      output text_data, value, cursor_col, cursor_row, cursor_en
   );
endinterface

// File: rtl/text_scanner.sv
// Raster text-mode scanner: walks the pixel raster, fetches one character per
// 8x16 cell from a synchronous text RAM and emits a 3-stage registered pixel stream.
module text_scanner #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int COLS      = 80,
   parameter int ROWS      = 30,
   parameter int ADDR_W    = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   text_scanner_if.master bus
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0]        r_h;
   logic [9:0]        r_v;
   logic [4:0]        r_frame_cnt;

   logic              w_h_wrap;
   logic              w_v_wrap;
   logic              w_vis;
   logic              w_hs_n;
   logic              w_vs_n;
   logic [6:0]        w_col;
   logic [5:0]        w_row;
   logic              w_hit;
   logic              w_cursor_on;
   logic              w_first;
   logic [ADDR_W-1:0] w_addr;

   logic [ADDR_W-1:0] r_s1_addr;
   logic [2:0]        r_s1_gx;
   logic [3:0]        r_s1_gy;
   logic              r_s1_de;
   logic              r_s1_hs_n;
   logic              r_s1_vs_n;
   logic              r_s1_cur;
   logic              r_s1_first;

   logic [2:0]        r_s2_gx;
   logic [3:0]        r_s2_gy;
   logic              r_s2_de;
   logic              r_s2_hs_n;
   logic              r_s2_vs_n;
   logic              r_s2_cur;
   logic              r_s2_first;

   logic              r_pixel;
   logic              r_de;
   logic              r_hs_n;
   logic              r_vs_n;
   logic              r_first;

   logic [3:0]        w_char;
   logic              w_unused_attr;

   // Stage 0: raster decode, cell address and cursor hit from the live counters
   always_comb begin
      w_h_wrap    = (r_h == H_LAST);
      w_v_wrap    = (r_v == V_LAST);
      w_vis       = (r_h < H_VIS) && (r_v < V_VIS);
      w_hs_n      = !((r_h >= HS_START) && (r_h < HS_END));
      w_vs_n      = !((r_v >= VS_START) && (r_v < VS_END));
      w_col       = r_h[9:3];
      w_row       = r_v[9:4];
      w_hit       = (int'(bus.cursor_col) < COLS) && (int'(bus.cursor_row) < ROWS) &&
                    (w_col == bus.cursor_col) && (w_row == {1'b0, bus.cursor_row});
      w_cursor_on = bus.cursor_en && w_hit && (r_v[3:0] >= 4'd14) && r_frame_cnt[4];
      w_first     = (r_h == 10'd0) && (r_v == 10'd0);
      if (w_vis) begin
         w_addr = ADDR_W'(int'(w_row) * COLS + int'(w_col));
      end else begin
         w_addr = {ADDR_W{1'b0}};
      end
   end

   // Raster counters and the frame counter whose MSB drives cursor blink
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h         <= 10'd0;
         r_v         <= 10'd0;
         r_frame_cnt <= 5'd0;
      end else if (w_h_wrap) begin
         r_h <= 10'd0;
         if (w_v_wrap) begin
            r_v         <= 10'd0;
            r_frame_cnt <= r_frame_cnt + 5'd1;
         end else begin
            r_v <= r_v + 10'd1;
         end
      end else begin
         r_h <= r_h + 10'd1;
      end
   end

   // Stage 1: RAM address issue plus the raster attributes travelling with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_addr  <= {ADDR_W{1'b0}};
         r_s1_gx    <= 3'd0;
         r_s1_gy    <= 4'd0;
         r_s1_de    <= 1'b0;
         r_s1_hs_n  <= 1'b1;
         r_s1_vs_n  <= 1'b1;
         r_s1_cur   <= 1'b0;
         r_s1_first <= 1'b0;
      end else begin
         r_s1_addr  <= w_addr;
         r_s1_gx    <= r_h[2:0];
         r_s1_gy    <= r_v[3:0];
         r_s1_de    <= w_vis;
         r_s1_hs_n  <= w_hs_n;
         r_s1_vs_n  <= w_vs_n;
         r_s1_cur   <= w_cursor_on;
         r_s1_first <= w_first;
      end
   end

   // Stage 2: aligned with the RAM read data and the glyph lookup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_gx    <= 3'd0;
         r_s2_gy    <= 4'd0;
         r_s2_de    <= 1'b0;
         r_s2_hs_n  <= 1'b1;
         r_s2_vs_n  <= 1'b1;
         r_s2_cur   <= 1'b0;
         r_s2_first <= 1'b0;
      end else begin
         r_s2_gx    <= r_s1_gx;
         r_s2_gy    <= r_s1_gy;
         r_s2_de    <= r_s1_de;
         r_s2_hs_n  <= r_s1_hs_n;
         r_s2_vs_n  <= r_s1_vs_n;
         r_s2_cur   <= r_s1_cur;
         r_s2_first <= r_s1_first;
      end
   end

   // Char is held at zero outside the visible area so reset and blanking read clean
   assign w_char        = r_s2_de ? bus.text_data[3:0] : 4'd0;
   assign w_unused_attr = ^bus.text_data[6:4];

   // Stage 3: registered video outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pixel <= 1'b0;
         r_de    <= 1'b0;
         r_hs_n  <= 1'b1;
         r_vs_n  <= 1'b1;
         r_first <= 1'b0;
      end else begin
         r_pixel <= r_s2_de & (bus.value ^ bus.text_data[7] ^ r_s2_cur);
         r_de    <= r_s2_de;
         r_hs_n  <= r_s2_hs_n;
         r_vs_n  <= r_s2_vs_n;
         r_first <= r_s2_first;
      end
   end

   assign bus.text_addr   = r_s1_addr;
   assign bus.char        = w_char;
   assign bus.X           = r_s2_gx;
   assign bus.Y           = r_s2_gy;
   assign bus.pixel       = r_pixel;
   assign bus.de          = r_de;
   assign bus.hsync       = r_hs_n;
   assign bus.vsync       = r_vs_n;
   assign bus.frame_start = r_first;
endmodule
